// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//
// Turns one 32-bit load/store from the MEM stage into two half-word accesses
// on a 16-bit asynchronous SRAM.  The low half-word goes first (LO), then the
// high half-word (HI).  Each phase lasts WAIT_CYCLES+1 cycles.  While a request
// is outstanding and the transaction has not reached DONE, SRAM_freeze holds
// every pipeline stage register.
//
// Handshake: the MEM stage raises wr_en or rd_en (req) and keeps the request
// and its operands stable until it sees ready.  ready is a one-cycle pulse in
// DONE; the pipeline advances on that edge and the controller returns to IDLE
// unconditionally.  A request still present in the following IDLE cycle is
// treated as a new transaction.  With both enables high the access is a write.
//
// Parameters:
//   BASE_ADDR   byte address mapped to SRAM word 0
//   WAIT_CYCLES extra wait cycles per half-word access (0..7)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      store / load request
//   address           byte address (offset from BASE_ADDR, 32-bit wrap)
//   write_data        store data
//   read_data         assembled load data, held until the next load
//   ready             transaction done this cycle
//   SRAM_freeze       pipeline hold
//   SRAM_ADDR         SRAM half-word address
//   SRAM_DQ_OUT/IN    pad data out / in
//   SRAM_DQ_OE        pad output enable
//   SRAM_WE_N         active-low write strobe
//   SRAM_OE_N         active-low output enable
//   o_dbg_state       current FSM state (0 IDLE, 1 LO, 2 HI, 3 DONE)
//   SRAM_FREEZE_CNT   saturating count of freeze cycles; present only when
//                     the macro SRAM_FREEZE_STATS_EN is defined
// ----------------------------------------------------------------------------
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        SRAM_freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic [1:0]  o_dbg_state
`ifdef SRAM_FREEZE_STATS_EN
    ,
    output logic [15:0] SRAM_FREEZE_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic        r_op_wr;
    logic [16:0] r_word;       // 32-bit word index within the SRAM
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;

    logic        w_req;
    logic        w_cnt_zero;
    logic [2:0]  w_wait;
    logic [31:0] w_off;
    logic        w_unused;

    assign w_req      = wr_en | rd_en;
    assign w_cnt_zero = (r_cnt == 3'd0);
    assign w_wait     = 3'(WAIT_CYCLES);
    assign w_off      = address - BASE_ADDR;
    // Byte-within-word and out-of-range offset bits do not reach the SRAM.
    assign w_unused   = ^{w_off[31:19], w_off[1:0]};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_req)      w_next_state = ST_LO;
            ST_LO:   if (w_cnt_zero) w_next_state = ST_HI;
            ST_HI:   if (w_cnt_zero) w_next_state = ST_DONE;
            ST_DONE:                 w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- Moore outputs (pins, ready) ----------------
    always_comb begin
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_OUT = 16'd0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        ready       = 1'b0;
        case (r_state)
            ST_LO: begin
                SRAM_ADDR = {r_word, 1'b0};
                if (r_op_wr) begin
                    SRAM_DQ_OUT = r_wdata[15:0];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end else begin
                    SRAM_OE_N   = 1'b0;
                end
            end
            ST_HI: begin
                SRAM_ADDR = {r_word, 1'b1};
                if (r_op_wr) begin
                    SRAM_DQ_OUT = r_wdata[31:16];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end else begin
                    SRAM_OE_N   = 1'b0;
                end
            end
            ST_DONE: ready = 1'b1;
            default: ;
        endcase
    end

    // Freeze follows the live request so the pipeline is released in DONE
    // and is never held while no memory instruction is present.
    assign SRAM_freeze = w_req & (r_state != ST_DONE);
    assign read_data   = r_read_data;
    assign o_dbg_state = r_state;

    // ---------------- transaction registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_op_wr     <= 1'b0;
            r_word      <= 17'd0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_cnt   <= w_wait;
                        r_op_wr <= wr_en;
                        r_word  <= w_off[18:2];
                        r_wdata <= write_data;
                    end
                end
                ST_LO: begin
                    if (w_cnt_zero) begin
                        r_cnt <= w_wait;   // reload for the HI phase
                        if (!r_op_wr) r_read_data[15:0] <= SRAM_DQ_IN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_HI: begin
                    if (w_cnt_zero) begin
                        if (!r_op_wr) r_read_data[31:16] <= SRAM_DQ_IN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRAM_FREEZE_STATS_EN
    logic [15:0] r_freeze_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freeze_cnt <= 16'd0;
        end else if (SRAM_freeze && (r_freeze_cnt != 16'hFFFF)) begin
            r_freeze_cnt <= r_freeze_cnt + 16'd1;
        end
    end

    assign SRAM_FREEZE_CNT = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller
//
// Bench for sram_controller with default parameters.  An SRAM pad model sits
// on the pins; a reference memory (associative array of half-words) and an
// expected read_data value are updated from the transaction rules and
// compared against the pad model contents and DUT outputs.
// ----------------------------------------------------------------------------
module tb_sram_controller;

    localparam logic [31:0] BASE       = 32'd1024;
    localparam int          WAITC      = 1;
    localparam int          PHASE_LEN  = WAITC + 1;
    localparam int          FREEZE_LEN = 1 + 2 * PHASE_LEN;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        SRAM_freeze;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_DQ_OE;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic [1:0]  o_dbg_state;
`ifdef SRAM_FREEZE_STATS_EN
    logic [15:0] SRAM_FREEZE_CNT;
`endif

    always #5 clk = ~clk;

    sram_controller #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .SRAM_freeze (SRAM_freeze),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .o_dbg_state (o_dbg_state)
`ifdef SRAM_FREEZE_STATS_EN
        ,
        .SRAM_FREEZE_CNT (SRAM_FREEZE_CNT)
`endif
    );

    // ---------------- SRAM pad model ----------------
    logic [15:0] sram_mem [0:262143];

    assign SRAM_DQ_IN = sram_mem[SRAM_ADDR];

    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_OE) sram_mem[SRAM_ADDR] <= SRAM_DQ_OUT;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] ref_mem [int];
    logic [31:0] written_q[$];   // byte addresses whose word is known
    logic [31:0] exp_rdata;
    int          checks = 0;
    int          errors = 0;

    // Half-word index of the low half of the word an address maps to.
    function automatic int half_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off >> 2) & 32'h1FFFF) * 2;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int h;
        h = half_idx(addr);
        return {ref_mem[h + 1], ref_mem[h]};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] data);
        int h;
        h = half_idx(addr);
        ref_mem[h]     = data[15:0];
        ref_mem[h + 1] = data[31:16];
        written_q.push_back(addr);
    endtask

    // ---------------- driver ----------------
    // Called between a falling edge and the next rising edge.  Presents the
    // request, samples once per cycle until ready, drops the request in the
    // ready cycle and returns in the following cycle (between edges again).
    task automatic run_txn(input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int fz, output int rdy, output int we_low,
                           output int oe_low, output logic [31:0] rdata,
                           output logic rdy_after);
        logic got;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        fz = 0; rdy = -1; we_low = 0; oe_low = 0; rdata = '0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (SRAM_freeze) fz++;
            if (!SRAM_WE_N) we_low++;
            if (!SRAM_OE_N) oe_low++;
            if (ready) begin
                got   = 1'b1;
                rdy   = c;
                rdata = read_data;
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        rdy_after = ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", o_dbg_state); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got %h exp 0", read_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (SRAM_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b exp 0", SRAM_freeze); end
        checks++; if (SRAM_ADDR !== 18'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", SRAM_ADDR); end
        checks++; if (SRAM_DQ_OUT !== 16'd0) begin errors++; $display("FAIL reset_dq_out got %h exp 0", SRAM_DQ_OUT); end
        checks++; if (SRAM_DQ_OE !== 1'b0) begin errors++; $display("FAIL reset_dq_oe got %b exp 0", SRAM_DQ_OE); end
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", SRAM_WE_N); end
        checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b exp 1", SRAM_OE_N); end
`ifdef SRAM_FREEZE_STATS_EN
        checks++; if (SRAM_FREEZE_CNT !== 16'd0) begin errors++; $display("FAIL reset_freeze_cnt got %0d exp 0", SRAM_FREEZE_CNT); end
`endif
        exp_rdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int fz, rdy, we_low, oe_low; logic [31:0] rdata; logic ra;
        run_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, fz, rdy, we_low, oe_low, rdata, ra);
        ref_write(32'd1024, 32'hDEADBEEF);
        checks++; if (fz !== FREEZE_LEN) begin errors++; $display("FAIL write_freeze_len got %0d exp %0d", fz, FREEZE_LEN); end
        checks++; if (rdy !== FREEZE_LEN) begin errors++; $display("FAIL write_ready_cycle got %0d exp %0d", rdy, FREEZE_LEN); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL write_ready_pulse got %b exp 0", ra); end
        checks++; if (we_low !== 2 * PHASE_LEN) begin errors++; $display("FAIL write_we_cycles got %0d exp %0d", we_low, 2 * PHASE_LEN); end
        checks++; if (sram_mem[0] !== 16'hBEEF) begin errors++; $display("FAIL write_word0 got %h exp beef", sram_mem[0]); end
        checks++; if (sram_mem[1] !== 16'hDEAD) begin errors++; $display("FAIL write_word1 got %h exp dead", sram_mem[1]); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL write_rdata_kept got %h exp %h", rdata, exp_rdata); end
    endtask

    task automatic test_readback();
        int fz, rdy, we_low, oe_low; logic [31:0] rdata; logic ra;
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, fz, rdy, we_low, oe_low, rdata, ra);
        exp_rdata = ref_word(32'd1024);
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_data got %h exp deadbeef", rdata); end
        checks++; if (we_low !== 0) begin errors++; $display("FAIL readback_we_cycles got %0d exp 0", we_low); end
        checks++; if (oe_low !== 2 * PHASE_LEN) begin errors++; $display("FAIL readback_oe_cycles got %0d exp %0d", oe_low, 2 * PHASE_LEN); end
        checks++; if (fz !== FREEZE_LEN) begin errors++; $display("FAIL readback_freeze_len got %0d exp %0d", fz, FREEZE_LEN); end
        checks++; if (read_data !== exp_rdata) begin errors++; $display("FAIL readback_hold got %h exp %h", read_data, exp_rdata); end
    endtask

    task automatic test_conflict();
        int fz, rdy, we_low, oe_low; logic [31:0] rdata; logic ra;
        run_txn(1'b1, 1'b1, 32'd1028, 32'h12345678, fz, rdy, we_low, oe_low, rdata, ra);
        ref_write(32'd1028, 32'h12345678);
        checks++; if (sram_mem[2] !== 16'h5678) begin errors++; $display("FAIL conflict_word2 got %h exp 5678", sram_mem[2]); end
        checks++; if (sram_mem[3] !== 16'h1234) begin errors++; $display("FAIL conflict_word3 got %h exp 1234", sram_mem[3]); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL conflict_rdata got %h exp %h", rdata, exp_rdata); end
        checks++; if (we_low !== 2 * PHASE_LEN) begin errors++; $display("FAIL conflict_we_cycles got %0d exp %0d", we_low, 2 * PHASE_LEN); end
    endtask

    // Address below BASE wraps to the top of the SRAM.
    task automatic test_wrap();
        int fz, rdy, we_low, oe_low; logic [31:0] rdata, d; logic ra;
        d = $urandom;
        run_txn(1'b1, 1'b0, BASE - 32'd4, d, fz, rdy, we_low, oe_low, rdata, ra);
        ref_write(BASE - 32'd4, d);
        checks++; if (sram_mem[18'h3FFFE] !== d[15:0]) begin errors++; $display("FAIL wrap_lo got %h exp %h", sram_mem[18'h3FFFE], d[15:0]); end
        checks++; if (sram_mem[18'h3FFFF] !== d[31:16]) begin errors++; $display("FAIL wrap_hi got %h exp %h", sram_mem[18'h3FFFF], d[31:16]); end
        run_txn(1'b0, 1'b1, BASE - 32'd3, 32'h0, fz, rdy, we_low, oe_low, rdata, ra);
        exp_rdata = ref_word(BASE - 32'd4);
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL wrap_read got %h exp %h", rdata, exp_rdata); end
    endtask

    task automatic test_random();
        int fz, rdy, we_low, oe_low, op, h; logic [31:0] rdata, a, d; logic ra;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 2);
            d  = $urandom;
            if (op == 1) begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                a = (a & ~32'd3) | 32'($urandom_range(0, 3));
                run_txn(1'b0, 1'b1, a, d, fz, rdy, we_low, oe_low, rdata, ra);
                exp_rdata = ref_word(a);
                checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rand_read n=%0d addr %h got %h exp %h", n, a, rdata, exp_rdata); end
                checks++; if (we_low !== 0) begin errors++; $display("FAIL rand_read_we n=%0d got %0d exp 0", n, we_low); end
            end else begin
                a = BASE + 32'($urandom_range(0, 8191));
                run_txn(1'b1, (op == 2), a, d, fz, rdy, we_low, oe_low, rdata, ra);
                ref_write(a, d);
                h = half_idx(a);
                checks++; if ({sram_mem[h + 1], sram_mem[h]} !== d) begin errors++; $display("FAIL rand_write n=%0d addr %h got %h exp %h", n, a, {sram_mem[h + 1], sram_mem[h]}, d); end
                checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rand_write_rdata n=%0d got %h exp %h", n, rdata, exp_rdata); end
            end
            checks++; if (fz !== FREEZE_LEN || rdy !== FREEZE_LEN || ra !== 1'b0) begin
                errors++; $display("FAIL rand_timing n=%0d freeze %0d ready_at %0d ready_next %b exp %0d %0d 0", n, fz, rdy, ra, FREEZE_LEN, FREEZE_LEN);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int fz, rdy, we_low, oe_low; logic [31:0] rdata, a; logic ra, hit;
        wr_en = 1'b1; rd_en = 1'b0; address = BASE + 32'h2000; write_data = $urandom;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk); #1;
            if (!SRAM_WE_N && SRAM_ADDR[0]) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_hi got %b exp 1", hit); end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", o_dbg_state); end
        checks++; if (SRAM_freeze !== 1'b0) begin errors++; $display("FAIL mid_freeze got %b exp 0", SRAM_freeze); end
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL mid_we_n got %b exp 1", SRAM_WE_N); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL mid_read_data got %h exp 0", read_data); end
        exp_rdata = 32'd0;
        rst = 1'b0;
        @(negedge clk);
        a = written_q[0];
        run_txn(1'b0, 1'b1, a, 32'h0, fz, rdy, we_low, oe_low, rdata, ra);
        exp_rdata = ref_word(a);
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL mid_after_read got %h exp %h", rdata, exp_rdata); end
        checks++; if (fz !== FREEZE_LEN) begin errors++; $display("FAIL mid_after_freeze got %0d exp %0d", fz, FREEZE_LEN); end
    endtask

    task automatic test_back_to_back();
        int fz1, fz2, rdy1, rdy2, we_low, oe_low, pulses, h; logic [31:0] r1, r2, a, d; logic ra1, ra2;
`ifdef SRAM_FREEZE_STATS_EN
        logic [15:0] cnt0;
        cnt0 = SRAM_FREEZE_CNT;
`endif
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        run_txn(1'b0, 1'b1, a, 32'h0, fz1, rdy1, we_low, oe_low, r1, ra1);
        exp_rdata = ref_word(a);
        d = $urandom;
        run_txn(1'b1, 1'b0, BASE + 32'h1F00, d, fz2, rdy2, we_low, oe_low, r2, ra2);
        ref_write(BASE + 32'h1F00, d);
        pulses = 0;
        if (rdy1 == FREEZE_LEN) pulses++;
        if (rdy2 == FREEZE_LEN) pulses++;
        checks++; if (fz1 + fz2 !== 2 * FREEZE_LEN) begin errors++; $display("FAIL b2b_freeze_total got %0d exp %0d", fz1 + fz2, 2 * FREEZE_LEN); end
        checks++; if (pulses !== 2 || ra1 !== 1'b0 || ra2 !== 1'b0) begin errors++; $display("FAIL b2b_ready_pulses got %0d (%b %b) exp 2", pulses, ra1, ra2); end
        checks++; if (r1 !== exp_rdata) begin errors++; $display("FAIL b2b_read got %h exp %h", r1, exp_rdata); end
        h = half_idx(BASE + 32'h1F00);
        checks++; if ({sram_mem[h + 1], sram_mem[h]} !== d) begin errors++; $display("FAIL b2b_write got %h exp %h", {sram_mem[h + 1], sram_mem[h]}, d); end
`ifdef SRAM_FREEZE_STATS_EN
        checks++; if (SRAM_FREEZE_CNT - cnt0 !== 16'(2 * FREEZE_LEN)) begin errors++; $display("FAIL b2b_freeze_cnt got %0d exp %0d", SRAM_FREEZE_CNT - cnt0, 2 * FREEZE_LEN); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write();
        test_readback();
        test_conflict();
        test_wrap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
